// File: rtl/turbosound_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : turbosound_bus_ctrl
// Description : Bus front end for a bank of YM2203-class sound chips.
//               Synchronises the AY-style BDIR/BC/DI bus and decodes select,
//               bank and register commands. Register writes are queued with
//               their target chip and replayed at a paced rate. Chip read
//               data is muxed back onto DO.
// Revision    : 1.0 - initial release
// ============================================================================
module turbosound_bus_ctrl #(
    parameter int NUM_CHIPS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int WR_GAP     = 4,
    localparam int SELW      = (NUM_CHIPS > 2) ? $clog2(NUM_CHIPS) : 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   CE,
    input  logic                   BDIR,
    input  logic                   BC,
    input  logic [7:0]             DI,
    output logic [7:0]             DO,
    input  logic [8*NUM_CHIPS-1:0] CHIP_DO,
    output logic                   CHIP_WR,
    output logic                   CHIP_ADDR,
    output logic [7:0]             CHIP_DI,
    output logic [SELW-1:0]        CHIP_SEL,
    output logic [NUM_CHIPS-1:0]   CHIP_CS_N,
    output logic                   FM_ENA,
    output logic                   STAT_SEL,
    output logic                   BUSY,
    output logic                   OVF
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int                c_PTRW     = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                c_GAPW     = $clog2(WR_GAP + 1);
    localparam logic [c_PTRW:0]   c_CNT_FULL = (c_PTRW + 1)'(FIFO_DEPTH);
    localparam logic [c_GAPW-1:0] c_GAP_LOAD = c_GAPW'(WR_GAP);

    // ------------------------------------------------------------------------
    // Bus synchroniser and access-event stage
    // ------------------------------------------------------------------------
    logic       r_bdir_m, r_bdir_s, r_bdir_d;
    logic       r_bc_m, r_bc_s;
    logic [7:0] r_di_m, r_di_s;
    logic       r_evt, r_evt_bc;
    logic [7:0] r_evt_di;
    logic       w_evt;

    // Two register stages on every bus input, plus one delayed BDIR_s for edges
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_bdir_m <= 1'b0;
            r_bdir_s <= 1'b0;
            r_bdir_d <= 1'b0;
            r_bc_m   <= 1'b0;
            r_bc_s   <= 1'b0;
            r_di_m   <= 8'h00;
            r_di_s   <= 8'h00;
        end else begin
            r_bdir_m <= BDIR;
            r_bdir_s <= r_bdir_m;
            r_bdir_d <= r_bdir_s;
            r_bc_m   <= BC;
            r_bc_s   <= r_bc_m;
            r_di_m   <= DI;
            r_di_s   <= r_di_m;
        end
    end

    // A held-high BDIR yields a single event; a low period re-arms it
    assign w_evt = r_bdir_s & ~r_bdir_d;

    // Capture the access with its BC/DI so decode happens one edge later
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_evt    <= 1'b0;
            r_evt_bc <= 1'b0;
            r_evt_di <= 8'h00;
        end else begin
            r_evt    <= w_evt;
            r_evt_bc <= r_bc_s;
            r_evt_di <= r_di_s;
        end
    end

    // ------------------------------------------------------------------------
    // Command decode and chip index
    // ------------------------------------------------------------------------
    logic            r_sel0;
    logic [2:0]      r_bank;
    logic            r_acc;
    logic            r_fm_ena;
    logic            r_stat_sel;
    logic            r_ovf;
    logic [3:0]      w_idx_full;
    logic [SELW-1:0] w_idx;
    logic            w_idx_ok;
    logic            w_is_sel, w_is_bank, w_is_latch, w_is_data;
    logic            w_latch_acc;
    logic            w_push_req;

    assign w_idx_full  = {r_bank, r_sel0};
    assign w_idx       = w_idx_full[SELW-1:0];
    // Indices past the populated chips are treated as "no chip"
    assign w_idx_ok    = (w_idx_full < 4'(NUM_CHIPS));

    assign w_is_sel    = r_evt &  r_evt_bc & (r_evt_di[7:3] == 5'b11111);
    assign w_is_bank   = r_evt &  r_evt_bc & (r_evt_di[7:3] == 5'b11110);
    assign w_is_latch  = r_evt &  r_evt_bc & (r_evt_di[7:4] != 4'hF);
    assign w_is_data   = r_evt & ~r_evt_bc & r_acc;
    // SSG registers (0x00-0x0F) are always reachable; FM registers need FM_ENA
    assign w_latch_acc = (r_evt_di[7:4] == 4'h0) | r_fm_ena;
    assign w_push_req  = w_idx_ok & ((w_is_latch & w_latch_acc) | w_is_data);

    // Select/bank/latch bookkeeping and the sticky overflow flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sel0     <= 1'b0;
            r_bank     <= 3'd0;
            r_acc      <= 1'b0;
            r_fm_ena   <= 1'b0;
            r_stat_sel <= 1'b1;
            r_ovf      <= 1'b0;
        end else if (w_is_sel) begin
            r_sel0     <= ~r_evt_di[0];
            r_stat_sel <=  r_evt_di[1];
            r_fm_ena   <= ~r_evt_di[2];
            r_acc      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_is_bank) begin
                r_bank <= r_evt_di[2:0];
                r_acc  <= 1'b0;
            end else if (w_is_latch) begin
                r_acc  <= w_latch_acc & w_idx_ok;
            end else if (w_is_data && !w_idx_ok) begin
                r_acc  <= 1'b0;
            end
            if (w_push_req && (r_count == c_CNT_FULL)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Write queue: {type, data, chip} per entry
    // ------------------------------------------------------------------------
    logic              r_mem_type [FIFO_DEPTH];
    logic [7:0]        r_mem_data [FIFO_DEPTH];
    logic [SELW-1:0]   r_mem_chip [FIFO_DEPTH];
    logic [c_PTRW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_PTRW:0]   r_count;
    logic [c_GAPW-1:0] r_gap;
    logic              w_full, w_empty, w_push, w_pop;

    assign w_full  = (r_count == c_CNT_FULL);
    assign w_empty = (r_count == '0);
    // A pop in the same cycle never makes room for a push against a full queue
    assign w_push  = w_push_req & ~w_full;
    assign w_pop   = ~w_empty & (r_gap == '0);

    // Queue storage; contents are don't-care while the pointers say empty
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_type[r_wr_ptr] <= ~r_evt_bc;
            r_mem_data[r_wr_ptr] <= r_evt_di;
            r_mem_chip[r_wr_ptr] <= w_idx;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTRW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTRW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTRW + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTRW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Pacing counter: loaded at each pop, then counts CE pulses down to zero
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_gap <= '0;
        end else if (w_pop) begin
            r_gap <= c_GAP_LOAD;
        end else if (CE && (r_gap != '0)) begin
            r_gap <= r_gap - c_GAPW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Chip write port
    // ------------------------------------------------------------------------
    logic            r_chip_wr;
    logic            r_wr_type;
    logic [7:0]      r_chip_di;
    logic [SELW-1:0] r_chip_sel;

    // Present the popped entry to the chips for exactly one CLK
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_chip_wr  <= 1'b0;
            r_wr_type  <= 1'b0;
            r_chip_di  <= 8'h00;
            r_chip_sel <= '0;
        end else begin
            r_chip_wr <= w_pop;
            if (w_pop) begin
                r_wr_type  <= r_mem_type[r_rd_ptr];
                r_chip_di  <= r_mem_data[r_rd_ptr];
                r_chip_sel <= r_mem_chip[r_rd_ptr];
            end
        end
    end

    assign CHIP_WR   = r_chip_wr;
    assign CHIP_ADDR = r_chip_wr ? r_wr_type : r_stat_sel;
    assign CHIP_DI   = r_chip_di;
    assign CHIP_SEL  = r_chip_sel;
    assign FM_ENA    = r_fm_ena;
    assign STAT_SEL  = r_stat_sel;
    assign OVF       = r_ovf;
    assign BUSY      = ~w_empty | (r_gap != '0);

    // Chip selects follow the write target during CHIP_WR, else the bus index
    always_comb begin
        CHIP_CS_N = '1;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            if (r_chip_wr) begin
                CHIP_CS_N[i] = (r_chip_sel != SELW'(i));
            end else if (w_idx_ok) begin
                CHIP_CS_N[i] = (w_idx != SELW'(i));
            end
        end
    end

    // Read mux straight from the chips; an unpopulated index reads as 0xFF
    always_comb begin
        DO = 8'hFF;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            if (w_idx_full == 4'(i)) begin
                DO = CHIP_DO[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/turbosound_bus_ctrl.md
# turbosound_bus_ctrl

Parametrised bus front end for a bank of NUM_CHIPS YM2203-class sound chips, replacing fixed two-chip select logic. It synchronises the AY-style BDIR/BC/DI bus and decodes chip-select, bank and FM-enable commands. Register writes are buffered in a FIFO tagged with the target chip and replayed to the chips at a paced rate of at most one write per WR_GAP CE pulses. Chip read data is muxed back onto DO.

## Interface
- NUM_CHIPS, 2, number of chips (2..8); SELW = max(1, clog2(NUM_CHIPS))
- FIFO_DEPTH, 4, write-queue entries (power of 2, ≥2)
- WR_GAP, 4, CE pulses enforced between consecutive chip writes (≥1)
- CLK  in  1  global clock
- RESET  in  1  synchronous, active-high reset
- CE  in  1  chip master-clock enable, used for write pacing
- BDIR  in  1  bus direction; a rising edge marks an access
- BC  in  1  bus control (1 = address/command, 0 = data)
- DI  in  8  bus data
- DO  out  8  read data from the selected chip
- CHIP_DO  in  8*NUM_CHIPS  chip read data; chip i on bits [8i+7:8i]
- CHIP_WR  out  1  one-CLK write strobe to the chips
- CHIP_ADDR  out  1  chip A0: queued entry type during CHIP_WR, otherwise STAT_SEL
- CHIP_DI  out  8  write data
- CHIP_SEL  out  SELW  target chip index of the current write
- CHIP_CS_N  out  NUM_CHIPS  active-low one-hot chip select; during CHIP_WR it follows CHIP_SEL, otherwise the current index
- FM_ENA  out  1  FM sound enabled
- STAT_SEL  out  1  status/read register select
- BUSY  out  1  queue non-empty or gap counter non-zero
- OVF  out  1  sticky flag: a write was dropped because the queue was full

## Operation
- Input sync: BDIR, BC and DI pass through two register stages (_s). Edge detect: the access event is BDIR_s high and the previous BDIR_s low.
- Current index: idx = {bank[2:0], sel0}, truncated to SELW bits. It is invalid if the untruncated value is ≥ NUM_CHIPS.
- On an access event with BC_s = 1:
  - DI_s = 0xF8–0xFF (select): sel0 ← ~DI_s[0], STAT_SEL ← DI_s[1], FM_ENA ← ~DI_s[2], acc ← 0, OVF ← 0.
  - DI_s = 0xF0–0xF7 (bank): bank ← DI_s[2:0], acc ← 0.
  - Otherwise (register latch): acc ← (DI_s[7:4] == 0) | FM_ENA. If the new acc is 1, push {type = 0, data = DI_s, chip = idx}.
- On an access event with BC_s = 0 and acc = 1: push {type = 1, data = DI_s, chip = idx}.
- Invalid idx: nothing is pushed, acc ← 0, all CHIP_CS_N bits are high outside CHIP_WR, DO = 0xFF.
- Push while full: the entry is dropped and OVF ← 1. A pop in the same cycle does not free a slot for that push.
- Drain: when the queue is non-empty and gap = 0, pop the head. Next cycle CHIP_WR = 1 with CHIP_ADDR = type, CHIP_DI = data, CHIP_SEL = chip. gap ← WR_GAP at the pop.
- gap decrements on each CE while non-zero.
- Each queued entry carries its own chip tag. A select or bank command issued while entries are queued does not retarget them.
- DO = CHIP_DO slice[idx], combinational. Reads bypass the queue, so BUSY = 1 means read data may predate queued writes.

## Timing
- Reset values: CHIP_WR 0, CHIP_ADDR 1, CHIP_DI 0x00, CHIP_SEL 0, CHIP_CS_N = ~1 (chip 0 selected), FM_ENA 0, STAT_SEL 1, BUSY 0, OVF 0, sel0 0, bank 0, acc 0, gap 0, queue empty.
- Latency: the first CLK edge sampling BDIR = 1 is edge 0. The push happens at edge 3. With the queue empty and gap = 0, the pop is at edge 4 and CHIP_WR is high for the cycle after edge 4.
- Consecutive CHIP_WR pulses are separated by at least WR_GAP CE pulses. A CE coincident with the pop cycle does not count.
- BDIR held high produces exactly one event. The next event needs BDIR_s low for at least one cycle.
- RESET mid-operation: the queue is flushed, any CHIP_WR in flight is deasserted at the next edge, and all state returns to reset values.
- Queue pointers wrap modulo FIFO_DEPTH. The count ranges from 0 to FIFO_DEPTH.

## Test plan
- Reset, then bus latch 0x07 followed by data 0x38 → CHIP_WR pulses {ADDR=0, DI=0x07, SEL=0} then {ADDR=1, DI=0x38, SEL=0}, separated by ≥4 CE; DO = CHIP_DO[7:0].
- Latch 0x28 with FM_ENA = 0 → no push. Select 0xFB (FM on), latch 0x28, data 0xF0 → two writes to chip 0 and FM_ENA = 1.
- NUM_CHIPS = 4: bank 0xF1, select 0xFF, latch/data → CHIP_SEL = 2 and CHIP_CS_N = 4'b1011. Bank 0xF3 with sel0 = 1 → idx 7, invalid: DO = 0xFF and no writes.
- Hold CE low and issue 6 bus writes (FIFO_DEPTH = 4) → exactly one CHIP_WR, 4 entries queued, 1 dropped, OVF = 1. Release CE → the remaining 4 drain in order. A later select command clears OVF.
- Queue 2 writes to chip 0, then select chip 1 before they drain → both drain with CHIP_SEL = 0.
- Assert RESET while 3 entries are queued → the next cycle shows BUSY = 0, CHIP_WR = 0, STAT_SEL = 1, and no further writes occur.
